// File: rtl/fft_pkg.sv
// Types and constants shared by the FFT datapath blocks.
package fft_pkg;

  localparam int TWIDDLE_ADDR_W = 9;
  localparam int MAX_LOG2N      = 10;

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } cplx16_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PAIR = 1'b1
  } feed_state_e;

  // Twiddle index for pair k: the full-size ROM is strided by 2^(MAX_LOG2N-log2N).
  function automatic logic [TWIDDLE_ADDR_W-1:0] twiddle_addr(
    input logic [TWIDDLE_ADDR_W-1:0] k,
    input int                        shift
  );
    return k << shift;
  endfunction

endpackage

// File: rtl/sample_buffer.sv
// Half-frame sample store: synchronous write, combinational read, no reset.
module sample_buffer
  import fft_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  cplx16_t           wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output cplx16_t           rd_data
);

  // Sized to the full address space so the single-slot case needs no special indexing.
  localparam int DEPTH = 32'd1 << ADDR_W;

  cplx16_t mem_r [0:DEPTH-1];

  // Sample write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/butterfly_feeder.sv
// Pairs x[k] with x[k+N/2] for a radix-2 butterfly, buffering the first half-frame.
module butterfly_feeder #(
  parameter int FFT_LOG2N      = 10,
  parameter int TWIDDLE_ADDR_W = 9
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  input  logic [31:0]               i_data,
  input  logic                      i_sync,
  output logic [31:0]               o_butterfly_top,
  output logic [31:0]               o_butterfly_bot,
  output logic [TWIDDLE_ADDR_W-1:0] o_twiddle_addr,
  output logic                      o_valid,
  output logic                      o_frame_done
);

  import fft_pkg::*;

  localparam int N         = 32'd1 << FFT_LOG2N;
  localparam int HALF      = N >> 1;
  localparam int CNT_W     = FFT_LOG2N;
  localparam int SLOT_W    = (FFT_LOG2N > 1) ? (FFT_LOG2N - 1) : 1;
  localparam int STRIDE_SH = MAX_LOG2N - FFT_LOG2N;

  feed_state_e                 state_r, state_nxt_s, eff_state_s;
  logic [CNT_W-1:0]            cnt_r, cnt_nxt_s, eff_cnt_s;
  logic [SLOT_W-1:0]           slot_s;
  logic                        last_s;
  logic                        wr_en_s;
  logic                        pair_fire_s;
  cplx16_t                     rd_data_s;
  logic [TWIDDLE_ADDR_W-1:0]   twid_s;

  cplx16_t                     top_r;
  cplx16_t                     bot_r;
  logic [TWIDDLE_ADDR_W-1:0]   twid_r;
  logic                        valid_r;
  logic                        done_r;

  // A sync cycle behaves as if the frame had just restarted at index 0.
  always_comb begin
    eff_cnt_s   = cnt_r;
    eff_state_s = state_r;
    if (i_sync) begin
      eff_cnt_s   = '0;
      eff_state_s = ST_FILL;
    end else begin
      eff_cnt_s   = cnt_r;
      eff_state_s = state_r;
    end
  end

  // Both halves use the low index bits as the buffer slot / pair number k.
  if (FFT_LOG2N > 1) begin : g_slot
    assign slot_s = eff_cnt_s[SLOT_W-1:0];
  end else begin : g_slot_single
    assign slot_s = 1'b0;
  end

  // Next-state, counter and datapath strobes.
  always_comb begin
    state_nxt_s = eff_state_s;
    cnt_nxt_s   = eff_cnt_s;
    last_s      = 1'b0;
    wr_en_s     = 1'b0;
    pair_fire_s = 1'b0;

    case (eff_state_s)
      ST_FILL: last_s = (eff_cnt_s == CNT_W'(HALF - 1));
      ST_PAIR: last_s = (eff_cnt_s == CNT_W'(N - 1));
      default: last_s = 1'b0;
    endcase

    if (i_valid) begin
      cnt_nxt_s   = eff_cnt_s + CNT_W'(32'd1);
      wr_en_s     = (eff_state_s == ST_FILL);
      pair_fire_s = (eff_state_s == ST_PAIR);
      if (last_s) begin
        state_nxt_s = (eff_state_s == ST_FILL) ? ST_PAIR : ST_FILL;
      end else begin
        state_nxt_s = eff_state_s;
      end
    end else begin
      state_nxt_s = eff_state_s;
      cnt_nxt_s   = eff_cnt_s;
    end
  end

  // Frame position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FILL;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  sample_buffer #(
    .ADDR_W (SLOT_W)
  ) u_sample_buffer (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (slot_s),
    .wr_data (cplx16_t'(i_data)),
    .rd_addr (slot_s),
    .rd_data (rd_data_s)
  );

  assign twid_s = twiddle_addr(TWIDDLE_ADDR_W'(slot_s), STRIDE_SH);

  // Output pair registers; data holds between pairs, strobes drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_r   <= '0;
      bot_r   <= '0;
      twid_r  <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else if (pair_fire_s) begin
      top_r   <= rd_data_s;
      bot_r   <= cplx16_t'(i_data);
      twid_r  <= twid_s;
      valid_r <= 1'b1;
      done_r  <= last_s;
    end else begin
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end
  end

  assign o_butterfly_top = top_r;
  assign o_butterfly_bot = bot_r;
  assign o_twiddle_addr  = twid_r;
  assign o_valid         = valid_r;
  assign o_frame_done    = done_r;

endmodule

// File: tb/tb_butterfly_feeder.sv
// Scoreboard bench for butterfly_feeder at FFT_LOG2N = 2, 10 and 1.
module tb_butterfly_feeder;

  typedef struct {
    logic [31:0] top;
    logic [31:0] bot;
    logic [8:0]  tw;
    logic        done;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  exp_t q2[$];
  exp_t q10[$];
  exp_t q1[$];

  logic        v2 = 1'b0, s2 = 1'b0, v10 = 1'b0, s10 = 1'b0, v1 = 1'b0, s1 = 1'b0;
  logic [31:0] d2 = '0, d10 = '0, d1 = '0;
  logic [31:0] top2, bot2, top10, bot10, top1, bot1;
  logic [8:0]  tw2, tw10, tw1;
  logic        ov2, fd2, ov10, fd10, ov1, fd1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  butterfly_feeder #(.FFT_LOG2N(2), .TWIDDLE_ADDR_W(9)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_valid(v2), .i_data(d2), .i_sync(s2),
    .o_butterfly_top(top2), .o_butterfly_bot(bot2), .o_twiddle_addr(tw2),
    .o_valid(ov2), .o_frame_done(fd2));

  butterfly_feeder #(.FFT_LOG2N(10), .TWIDDLE_ADDR_W(9)) dut10 (
    .clk(clk), .rst_n(rst_n), .i_valid(v10), .i_data(d10), .i_sync(s10),
    .o_butterfly_top(top10), .o_butterfly_bot(bot10), .o_twiddle_addr(tw10),
    .o_valid(ov10), .o_frame_done(fd10));

  butterfly_feeder #(.FFT_LOG2N(1), .TWIDDLE_ADDR_W(9)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_valid(v1), .i_data(d1), .i_sync(s1),
    .o_butterfly_top(top1), .o_butterfly_bot(bot1), .o_twiddle_addr(tw1),
    .o_valid(ov1), .o_frame_done(fd1));

  // Present one input cycle to the selected instance; the others idle.
  task automatic drv(input int which, input logic v, input logic [31:0] d, input logic s);
    @(negedge clk);
    v2 = 1'b0; s2 = 1'b0; v10 = 1'b0; s10 = 1'b0; v1 = 1'b0; s1 = 1'b0;
    case (which)
      2:  begin v2 = v;  d2 = d;  s2 = s;  end
      10: begin v10 = v; d10 = d; s10 = s; end
      default: begin v1 = v; d1 = d; s1 = s; end
    endcase
  endtask

  // Expected pair for the sample just driven: visible one edge later.
  task automatic expect_pair(input int which, input logic [31:0] t, input logic [31:0] b,
                             input logic [8:0] tw, input logic done);
    exp_t e;
    e.top = t; e.bot = b; e.tw = tw; e.done = done; e.cyc = cyc + 1;
    case (which)
      2:  q2.push_back(e);
      10: q10.push_back(e);
      default: q1.push_back(e);
    endcase
  endtask

  task automatic cmp_pair(input string nm, input exp_t e, input logic [31:0] t,
                          input logic [31:0] b, input logic [8:0] tw, input logic fd);
    checks++;
    if (t !== e.top || b !== e.bot || tw !== e.tw || fd !== e.done || cyc != e.cyc) begin
      failures++;
      $display("FAIL %s pair: got top=%h bot=%h tw=%0d done=%b cyc=%0d, want top=%h bot=%h tw=%0d done=%b cyc=%0d",
               nm, t, b, tw, fd, cyc, e.top, e.bot, e.tw, e.done, e.cyc);
    end
  endtask

  task automatic chk_port(input string nm, input int which, input logic v, input logic fd,
                          input logic [31:0] t, input logic [31:0] b, input logic [8:0] tw);
    exp_t e;
    int   n;
    if (fd && !v) begin
      checks++;
      failures++;
      $display("FAIL %s frame_done: got 1 with o_valid=0, want 0", nm);
    end
    if (v) begin
      case (which)
        2:  n = q2.size();
        10: n = q10.size();
        default: n = q1.size();
      endcase
      if (n == 0) begin
        checks++;
        failures++;
        $display("FAIL %s unexpected pair: got top=%h bot=%h tw=%0d at cyc=%0d, want no output", nm, t, b, tw, cyc);
      end else begin
        case (which)
          2:  e = q2.pop_front();
          10: e = q10.pop_front();
          default: e = q1.pop_front();
        endcase
        cmp_pair(nm, e, t, b, tw, fd);
      end
    end
  endtask

  task automatic chk_zero(input string nm, input logic v, input logic fd,
                          input logic [31:0] t, input logic [31:0] b, input logic [8:0] tw);
    checks++;
    if (v !== 1'b0 || fd !== 1'b0 || t !== 32'h0 || b !== 32'h0 || tw !== 9'd0) begin
      failures++;
      $display("FAIL %s reset outputs: got v=%b done=%b top=%h bot=%h tw=%0d, want all 0", nm, v, fd, t, b, tw);
    end
  endtask

  task automatic chk_empty(input string nm, input int n);
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL %s missing pairs: got %0d outstanding, want 0", nm, n);
    end
  endtask

  task automatic monitor();
    while (!stim_done) begin
      @(negedge clk);
      chk_port("n2", 2, ov2, fd2, top2, bot2, tw2);
      chk_port("n1024", 10, ov10, fd10, top10, bot10, tw10);
      chk_port("n2pt", 1, ov1, fd1, top1, bot1, tw1);
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        repeat (3) @(negedge clk);
        chk_zero("n2", ov2, fd2, top2, bot2, tw2);
        chk_zero("n1024", ov10, fd10, top10, bot10, tw10);
        chk_zero("n2pt", ov1, fd1, top1, bot1, tw1);
        #2 rst_n = 1'b1;

        // Back-to-back four-point frame.
        drv(2, 1'b1, 32'h3C003C00, 1'b0);
        drv(2, 1'b1, 32'h40004000, 1'b0);
        drv(2, 1'b1, 32'h38003800, 1'b0);
        expect_pair(2, 32'h3C003C00, 32'h38003800, 9'd0, 1'b0);
        drv(2, 1'b1, 32'h3C003C00, 1'b0);
        expect_pair(2, 32'h40004000, 32'h3C003C00, 9'd256, 1'b1);

        // Same frame with an idle cycle after every sample.
        drv(2, 1'b1, 32'h3C003C00, 1'b0); drv(2, 1'b0, 32'hDEADBEEF, 1'b0);
        drv(2, 1'b1, 32'h40004000, 1'b0); drv(2, 1'b0, 32'hDEADBEEF, 1'b0);
        drv(2, 1'b1, 32'h38003800, 1'b0);
        expect_pair(2, 32'h3C003C00, 32'h38003800, 9'd0, 1'b0);
        drv(2, 1'b0, 32'hDEADBEEF, 1'b0);
        drv(2, 1'b1, 32'h3C003C00, 1'b0);
        expect_pair(2, 32'h40004000, 32'h3C003C00, 9'd256, 1'b1);
        drv(2, 1'b0, 32'hDEADBEEF, 1'b0);

        // Sync arriving in the second half restarts the frame at that sample.
        drv(2, 1'b1, 32'h11112222, 1'b0);
        drv(2, 1'b1, 32'h33334444, 1'b0);
        drv(2, 1'b1, 32'h55556666, 1'b0);
        expect_pair(2, 32'h11112222, 32'h55556666, 9'd0, 1'b0);
        drv(2, 1'b1, 32'h77778888, 1'b1);
        drv(2, 1'b1, 32'h9999AAAA, 1'b0);
        drv(2, 1'b1, 32'hBBBBCCCC, 1'b0);
        expect_pair(2, 32'h77778888, 32'hBBBBCCCC, 9'd0, 1'b0);
        drv(2, 1'b1, 32'hDDDDEEEE, 1'b0);
        expect_pair(2, 32'h9999AAAA, 32'hDDDDEEEE, 9'd256, 1'b1);

        // Two-point frames: every second sample completes a frame.
        drv(1, 1'b1, 32'hA0A0A0A0, 1'b0);
        drv(1, 1'b1, 32'hB1B1B1B1, 1'b0);
        expect_pair(1, 32'hA0A0A0A0, 32'hB1B1B1B1, 9'd0, 1'b1);
        drv(1, 1'b1, 32'hC2C2C2C2, 1'b0);
        drv(1, 1'b0, 32'h0, 1'b0);
        drv(1, 1'b1, 32'hD3D3D3D3, 1'b0);
        expect_pair(1, 32'hC2C2C2C2, 32'hD3D3D3D3, 9'd0, 1'b1);

        // Two 1024-point ramp frames.
        for (int f = 0; f < 2; f++) begin
          for (int i = 0; i < 1024; i++) begin
            drv(10, 1'b1, 32'(i), 1'b0);
            if (i >= 512) expect_pair(10, 32'(i - 512), 32'(i), 9'(i - 512), (i == 1023));
          end
        end

        // Reset mid-frame, asynchronous to the clock.
        drv(2, 1'b1, 32'h0000AAAA, 1'b0);
        drv(2, 1'b1, 32'h0000BBBB, 1'b0);
        drv(2, 1'b1, 32'h0000CCCC, 1'b0);
        expect_pair(2, 32'h0000AAAA, 32'h0000CCCC, 9'd0, 1'b0);
        drv(2, 1'b0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_zero("n2 async", ov2, fd2, top2, bot2, tw2);
        @(negedge clk);
        #2 rst_n = 1'b1;
        drv(2, 1'b1, 32'h12345678, 1'b0);
        drv(2, 1'b1, 32'h23456789, 1'b0);
        drv(2, 1'b1, 32'h3456789A, 1'b0);
        expect_pair(2, 32'h12345678, 32'h3456789A, 9'd0, 1'b0);
        drv(2, 1'b1, 32'h456789AB, 1'b0);
        expect_pair(2, 32'h23456789, 32'h456789AB, 9'd256, 1'b1);

        repeat (4) drv(2, 1'b0, 32'h0, 1'b0);
        stim_done = 1'b1;
      end
    join
    chk_empty("n2", q2.size());
    chk_empty("n1024", q10.size());
    chk_empty("n2pt", q1.size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/butterfly_feeder.md
BUTTERFLY_FEEDER -- requirements
Module: butterfly_feeder

Interface
REQ-001 Parameter FFT_LOG2N, default 10, log2 of FFT frame length N; legal range 1..10.
REQ-002 Parameter TWIDDLE_ADDR_W, default 9, twiddle ROM address width; fixed at 9 for full_butterfly compatibility.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_valid  input  1  i_data carries a sample this cycle; no ready, always accepted.
REQ-006 i_data  input  32  complex FP16 sample, real [31:16], imag [15:0].
REQ-007 i_sync  input  1  frame restart; the sample on this cycle, if valid, is index 0.
REQ-008 o_butterfly_top  output  32  buffered sample x[k].
REQ-009 o_butterfly_bot  output  32  incoming sample x[k+N/2].
REQ-010 o_twiddle_addr  output  9  twiddle address for pair k.
REQ-011 o_valid  output  1  outputs form a valid pair; connects to full_butterfly i_valid.
REQ-012 o_frame_done  output  1  one-cycle pulse with the last pair of a frame.

Function
REQ-013 HALF = N/2; STRIDE = 2^(10-FFT_LOG2N); sample counter width FFT_LOG2N.
REQ-014 States: FILL (accepting indices 0..HALF-1), PAIR (accepting indices HALF..N-1); FILL after reset.
REQ-015 In FILL, each valid sample is written to buffer slot cnt[FFT_LOG2N-2:0], no output.
REQ-016 In PAIR, each valid sample at index HALF+k produces, one cycle later, top=buf[k], bot=i_data, twiddle=k*STRIDE, o_valid=1.
REQ-017 Latency: exactly 1 clock from the accepting edge to registered outputs; outputs hold their values when o_valid=0.
REQ-018 FILL->PAIR after accepting index HALF-1; PAIR->FILL after accepting index N-1, counter wraps to 0.
REQ-019 o_frame_done asserts in the same cycle as o_valid for pair k=HALF-1.
REQ-020 Cycles with i_valid=0 do not advance the counter or state; gaps of any length are legal.
REQ-021 i_sync=1: counter forced to 0 and state to FILL; with i_valid=1 the sample is written as index 0; no pair output that cycle.
REQ-022 i_sync in PAIR abandons the partial frame without o_frame_done.
REQ-023 FFT_LOG2N=1: HALF=1, buffer depth 1, pairs on every second valid sample, twiddle always 0.
REQ-024 Twiddle computed as a shift (k << (10-FFT_LOG2N)), no multiplier; result always < 512.
REQ-025 Buffer read of slot k and write of a new frame's slot k never overlap within one cycle; no bypass needed.

Reset
REQ-026 rst_n low: state FILL, counter 0, o_valid 0, o_frame_done 0, o_butterfly_top/bot 0, o_twiddle_addr 0.
REQ-027 Buffer contents are not reset; reset mid-frame discards the partial frame; first sample after release is index 0.
REQ-028 Reset assertion is asynchronous; deassertion is synchronised externally.

Structure
REQ-029 Shared package fft_pkg holds cplx16_t (packed real/imag FP16), TWIDDLE_ADDR_W=9, MAX_LOG2N=10, and the state enum.
REQ-030 One sub-module, sample_buffer: HALF x 32 simple dual-port, synchronous write, combinational read, no reset.

Verification
REQ-031 FFT_LOG2N=2, inputs 3C003C00, 40004000, 38003800, 3C003C00 back-to-back -> (top 3C003C00, bot 38003800, twid 0) then (top 40004000, bot 3C003C00, twid 256, frame_done=1).
REQ-032 Same frame with one idle cycle between every sample -> identical pairs, each 1 cycle after its accepting edge, o_valid low elsewhere.
REQ-033 FFT_LOG2N=10, ramp data 0..1023 -> 512 pairs, top=k, bot=k+512, twid=k, frame_done only on k=511; second frame identical.
REQ-034 FFT_LOG2N=2, i_sync with sample 3 (PAIR state) -> no output that cycle, no frame_done, next 3 samples complete a frame with sync sample as x0.
REQ-035 rst_n pulsed low after 3 samples, asynchronous to clk -> outputs 0 immediately; next 4 samples form a correct frame.
REQ-036 Streamed into full_butterfly: pair (3C003C00, 38003800, twid 0) -> butterfly outputs 3E003E00 / 38003800 after its pipeline latency.
